// File: rtl/cnt_seq_checker.sv
// Sequence/complement scoreboard for a WIDTH-bit synchronous counter.
// Optional down-count support via `CNT_SEQ_CHK_DOWN_EN (adds the dir input).
module cnt_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int SYNC_LEN = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] qbar,
`ifdef CNT_SEQ_CHK_DOWN_EN
  input  logic             dir,
`endif
  output logic             locked,
  output logic             err_pulse,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count
);

  // state  | meaning
  // IDLE   | nothing sampled since reset
  // SYNC   | counting consecutive correct increments toward SYNC_LEN
  // LOCKED | tracking sequence; breaks are reported as errors
  typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

  localparam logic [3:0] SYNC_LEN_C = 4'(SYNC_LEN);

  state_t           state_q;
  logic [WIDTH-1:0] prev_q;
  logic [3:0]       match_cnt_q;
  logic             locked_q;
  logic             err_pulse_q;
  logic [1:0]       err_code_q;
  logic [CNT_W-1:0] err_count_q;
  logic [CNT_W-1:0] wrap_count_q;

  logic             dir_up;
  logic [WIDTH-1:0] exp_d;
  logic [3:0]       match_cnt_d;
  logic             seq_ok;
  logic             seq_err;
  logic             cmp_err;
  logic             wrap_hit;

  always_comb begin
`ifdef CNT_SEQ_CHK_DOWN_EN
    dir_up = dir;
`else
    dir_up = 1'b1;
`endif
    exp_d       = dir_up ? (prev_q + WIDTH'(1)) : (prev_q - WIDTH'(1));
    seq_ok      = (q == exp_d);
    seq_err     = (state_q == LOCKED) && !seq_ok;
    cmp_err     = (qbar != ~q);
    // Direction decides which end of the range counts as a wrap.
    wrap_hit    = dir_up ? ((prev_q == '1) && (q == '0))
                         : ((prev_q == '0) && (q == '1));
    match_cnt_d = match_cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      match_cnt_q  <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= 2'b00;
      err_count_q  <= '0;
      wrap_count_q <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      err_code_q  <= 2'b00;
      if (en) begin
        prev_q <= q;
        case (state_q)
          IDLE: begin
            match_cnt_q <= '0;
            state_q     <= SYNC;
          end
          SYNC: begin
            if (seq_ok) begin
              match_cnt_q <= match_cnt_d;
              if (match_cnt_d == SYNC_LEN_C) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              match_cnt_q <= '0;
            end
          end
          LOCKED: begin
            if (!seq_ok) begin
              match_cnt_q <= '0;
              state_q     <= SYNC;
              locked_q    <= 1'b0;
            end
            if (wrap_hit && (wrap_count_q != '1))
              wrap_count_q <= wrap_count_q + CNT_W'(1);
          end
          default: begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
          end
        endcase
        // A sample with both faults is still one erroneous sample.
        if (seq_err || cmp_err) begin
          err_pulse_q <= 1'b1;
          err_code_q  <= {cmp_err, seq_err};
          if (err_count_q != '1)
            err_count_q <= err_count_q + CNT_W'(1);
        end
      end
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_code   = err_code_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Directed self-checking bench for cnt_seq_checker (WIDTH=4, SYNC_LEN=2, CNT_W=8).
module tb_cnt_seq_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] q;
  logic [3:0] qbar;
`ifdef CNT_SEQ_CHK_DOWN_EN
  logic       dir;
`endif
  logic       locked;
  logic       err_pulse;
  logic [1:0] err_code;
  logic [7:0] err_count;
  logic [7:0] wrap_count;

  int errors = 0;
  int checks = 0;

  cnt_seq_checker #(.WIDTH(4), .SYNC_LEN(2), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .q          (q),
    .qbar       (qbar),
`ifdef CNT_SEQ_CHK_DOWN_EN
    .dir        (dir),
`endif
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_code   (err_code),
    .err_count  (err_count),
    .wrap_count (wrap_count)
  );

  always #5 clk = ~clk;

  // Apply one sample, take the edge, and settle 1 time unit past it.
  task automatic drive(input logic e, input logic [3:0] qv, input logic [3:0] qb);
    en   = e;
    q    = qv;
    qbar = qb;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ok(input logic [3:0] qv);
    drive(1'b1, qv, ~qv);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b1, 4'h3, 4'h3);
    drive(1'b1, 4'h4, 4'h4);
    checks++;
    if ({locked, err_pulse, err_code, err_count, wrap_count} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got lk=%0b ep=%0b ec=%0d cnt=%0d wr=%0d, need all 0",
               locked, err_pulse, err_code, err_count, wrap_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_lock;
    drive_ok(4'h3);
    drive_ok(4'h4);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL lock_early: locked=%0b need 0", locked);
    end
    drive_ok(4'h5);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL lock_rise: locked=%0b need 1", locked);
    end
    checks++;
    if (err_count !== 8'd0 || err_pulse !== 1'b0) begin
      errors++; $display("FAIL lock_noerr: err_count=%0d err_pulse=%0b need 0/0", err_count, err_pulse);
    end
    drive_ok(4'h6);
  endtask

  task automatic test_wrap;
    int pulses = 0;
    for (int v = 7; v <= 17; v++) begin
      drive_ok(4'(v));
      if (err_pulse !== 1'b0) pulses++;
    end
    checks++;
    if (wrap_count !== 8'd1) begin
      errors++; $display("FAIL wrap_count: got %0d need 1", wrap_count);
    end
    checks++;
    if (pulses != 0 || locked !== 1'b1) begin
      errors++; $display("FAIL wrap_clean: pulses=%0d locked=%0b need 0/1", pulses, locked);
    end
  endtask

  task automatic test_seq_err;
    for (int v = 2; v <= 7; v++) drive_ok(4'(v));
    drive_ok(4'h9);
    checks++;
    if (err_pulse !== 1'b1 || err_code !== 2'b01) begin
      errors++; $display("FAIL seq_err_pulse: ep=%0b code=%0b need 1/01", err_pulse, err_code);
    end
    checks++;
    if (locked !== 1'b0 || err_count !== 8'd1) begin
      errors++; $display("FAIL seq_err_state: locked=%0b cnt=%0d need 0/1", locked, err_count);
    end
    drive_ok(4'hA);
    checks++;
    if (err_pulse !== 1'b0 || err_code !== 2'b00 || locked !== 1'b0) begin
      errors++; $display("FAIL seq_err_clear: ep=%0b code=%0b lk=%0b need 0/00/0", err_pulse, err_code, locked);
    end
    drive_ok(4'hB);
    checks++;
    if (locked !== 1'b1 || err_count !== 8'd1) begin
      errors++; $display("FAIL relock: locked=%0b cnt=%0d need 1/1", locked, err_count);
    end
  endtask

  task automatic test_cmp_err;
    for (int v = 12; v <= 20; v++) drive_ok(4'(v));
    drive(1'b1, 4'h5, 4'hB);
    checks++;
    if (err_pulse !== 1'b1 || err_code !== 2'b10 || locked !== 1'b1 || err_count !== 8'd2) begin
      errors++; $display("FAIL cmp_err: ep=%0b code=%0b lk=%0b cnt=%0d need 1/10/1/2",
                         err_pulse, err_code, locked, err_count);
    end
    checks++;
    if (wrap_count !== 8'd2) begin
      errors++; $display("FAIL cmp_wrap: wrap_count=%0d need 2", wrap_count);
    end
    drive(1'b1, 4'h8, 4'hA);
    checks++;
    if (err_pulse !== 1'b1 || err_code !== 2'b11 || locked !== 1'b0 || err_count !== 8'd3) begin
      errors++; $display("FAIL both_err: ep=%0b code=%0b lk=%0b cnt=%0d need 1/11/0/3",
                         err_pulse, err_code, locked, err_count);
    end
  endtask

  task automatic test_en_gap;
    drive(1'b0, 4'h3, 4'h3);
    checks++;
    if (err_pulse !== 1'b0 || err_code !== 2'b00 || err_count !== 8'd3) begin
      errors++; $display("FAIL gap_clear: ep=%0b code=%0b cnt=%0d need 0/00/3", err_pulse, err_code, err_count);
    end
    drive(1'b0, 4'hF, 4'hF);
    drive(1'b0, 4'h0, 4'h0);
    drive_ok(4'h9);
    checks++;
    if (locked !== 1'b0 || err_pulse !== 1'b0) begin
      errors++; $display("FAIL gap_sync: lk=%0b ep=%0b need 0/0", locked, err_pulse);
    end
    drive_ok(4'hA);
    checks++;
    if (locked !== 1'b1 || err_count !== 8'd3) begin
      errors++; $display("FAIL gap_relock: lk=%0b cnt=%0d need 1/3", locked, err_count);
    end
  endtask

  task automatic test_saturation;
    int exp_wrap = 2;
    logic [3:0] p = 4'hA;
    logic [3:0] nv;
    for (int k = 0; k < 300; k++) begin
      nv = p + 4'd1;
      if (p == 4'hF) exp_wrap++;
      drive(1'b1, nv, nv);
      p = nv;
    end
    checks++;
    if (err_count !== 8'd255) begin
      errors++; $display("FAIL err_sat: err_count=%0d need 255", err_count);
    end
    checks++;
    if (wrap_count !== 8'(exp_wrap) || locked !== 1'b1) begin
      errors++; $display("FAIL sat_wrap: wrap=%0d lk=%0b need %0d/1", wrap_count, locked, exp_wrap);
    end
    checks++;
    if (err_pulse !== 1'b1 || err_code !== 2'b10) begin
      errors++; $display("FAIL sat_pulse: ep=%0b code=%0b need 1/10", err_pulse, err_code);
    end
    rst = 1'b1;
    drive(1'b1, 4'h7, 4'h7);
    checks++;
    if ({locked, err_pulse, err_code, err_count, wrap_count} !== 20'h0) begin
      errors++; $display("FAIL rst_mid: lk=%0b ep=%0b ec=%0d cnt=%0d wr=%0d need all 0",
                         locked, err_pulse, err_code, err_count, wrap_count);
    end
    rst = 1'b0;
    drive_ok(4'h2);
    drive_ok(4'h3);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL rst_idle: locked=%0b need 0 after two samples", locked);
    end
    drive_ok(4'h4);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL rst_relock: locked=%0b need 1", locked);
    end
  endtask

`ifdef CNT_SEQ_CHK_DOWN_EN
  task automatic test_down;
    rst = 1'b1; drive(1'b0, 4'h0, 4'hF); rst = 1'b0;
    dir = 1'b0;
    drive_ok(4'h2); drive_ok(4'h1); drive_ok(4'h0);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL down_lock: locked=%0b need 1", locked);
    end
    drive_ok(4'hF);
    checks++;
    if (wrap_count !== 8'd1 || err_count !== 8'd0 || locked !== 1'b1) begin
      errors++; $display("FAIL down_wrap: wr=%0d cnt=%0d lk=%0b need 1/0/1", wrap_count, err_count, locked);
    end
    rst = 1'b1; drive(1'b0, 4'h0, 4'hF); rst = 1'b0;
    dir = 1'b1;
    drive_ok(4'h2); drive_ok(4'h1); drive_ok(4'h0); drive_ok(4'hF);
    checks++;
    if (locked !== 1'b0 || err_count !== 8'd0 || wrap_count !== 8'd0) begin
      errors++; $display("FAIL up_on_down: lk=%0b cnt=%0d wr=%0d need 0/0/0", locked, err_count, wrap_count);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; q = '0; qbar = '1;
`ifdef CNT_SEQ_CHK_DOWN_EN
    dir = 1'b1;
`endif
    test_reset;
    test_lock;
    test_wrap;
    test_seq_err;
    test_cmp_err;
    test_en_gap;
    test_saturation;
`ifdef CNT_SEQ_CHK_DOWN_EN
    test_down;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
